// File: rtl/logic_cmd_sequencer.sv
// Command FIFO and result slot sitting in front of the combinational 4-bit logic unit.
// Optional LOGIC_SEQ_BYPASS_EN lets a command reach the logic unit in its arrival cycle when the block is idle.
module logic_cmd_sequencer #(
    parameter int D_S   = 4,
    parameter int D_W   = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     cmd_valid_in,
    output logic                     cmd_ready_out,
    input  logic [D_S-1:0]           cmd_a_in,
    input  logic [D_S-1:0]           cmd_b_in,
    input  logic [D_W-1:0]           cmd_opcode_in,
    output logic [D_S-1:0]           a_out,
    output logic [D_S-1:0]           b_out,
    output logic [D_W-1:0]           opcode_out,
    input  logic [D_S-1:0]           result_in,
    output logic                     res_valid_out,
    input  logic                     res_ready_in,
    output logic [D_S-1:0]           res_data_out,
    output logic [D_W-1:0]           res_opcode_out,
    output logic [$clog2(DEPTH):0]   count_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [D_S-1:0] mem_a  [DEPTH];
    logic [D_S-1:0] mem_b  [DEPTH];
    logic [D_W-1:0] mem_op [DEPTH];

    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           res_valid;
    logic [D_S-1:0] res_data;
    logic [D_W-1:0] res_opcode;

    logic not_empty;
    logic slot_free;
    logic push;
    logic take_bypass;
    logic fifo_push;
    logic fifo_pop;
    logic capture;

    assign not_empty     = (count != '0);
    assign cmd_ready_out = rst_n_in & (count < FULL);
    assign push          = cmd_valid_in & cmd_ready_out;
    assign slot_free     = !res_valid | res_ready_in;
    assign fifo_pop      = not_empty & slot_free;

    // A bypassed command goes straight to the result slot and never occupies a FIFO entry.
`ifdef LOGIC_SEQ_BYPASS_EN
    assign take_bypass = !not_empty & slot_free & push;
`else
    assign take_bypass = 1'b0;
`endif

    assign fifo_push = push & !take_bypass;
    assign capture   = fifo_pop | take_bypass;

    always_comb begin
        a_out      = '0;
        b_out      = '0;
        opcode_out = '0;
        if (not_empty) begin
            a_out      = mem_a[rd_ptr];
            b_out      = mem_b[rd_ptr];
            opcode_out = mem_op[rd_ptr];
        end
`ifdef LOGIC_SEQ_BYPASS_EN
        else if (take_bypass) begin
            a_out      = cmd_a_in;
            b_out      = cmd_b_in;
            opcode_out = cmd_opcode_in;
        end
`endif
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk_in) begin
        if (fifo_push) begin
            mem_a[wr_ptr]  <= cmd_a_in;
            mem_b[wr_ptr]  <= cmd_b_in;
            mem_op[wr_ptr] <= cmd_opcode_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_opcode <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(fifo_push) - CW'(fifo_pop);
            if (capture) begin
                res_valid  <= 1'b1;
                res_data   <= result_in;
                res_opcode <= opcode_out;
            end else if (res_ready_in) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign res_valid_out  = res_valid;
    assign res_data_out   = res_data;
    assign res_opcode_out = res_opcode;
    assign count_out      = count;

endmodule

// File: tb/tb_logic_cmd_sequencer.sv
// Randomised bench for logic_cmd_sequencer against a queue-based model; honours LOGIC_SEQ_BYPASS_EN.
module tb_logic_cmd_sequencer;
    localparam int DEPTH = 4;
`ifdef LOGIC_SEQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
    } cmd_t;

    typedef struct {
        logic [3:0] d;
        logic [1:0] op;
        int         cyc;
    } res_t;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       cmd_valid_in;
    logic       cmd_ready_out;
    logic [3:0] cmd_a_in;
    logic [3:0] cmd_b_in;
    logic [1:0] cmd_opcode_in;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic [1:0] opcode_out;
    logic [3:0] result_in;
    logic       res_valid_out;
    logic       res_ready_in;
    logic [3:0] res_data_out;
    logic [1:0] res_opcode_out;
    logic [2:0] count_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcount = 0;
    int push_cyc = 0;
    bit model_ok = 1'b0;

    cmd_t q[$];
    res_t exp_q[$];
    res_t got[$];
    logic       m_valid = 1'b0;
    logic [3:0] m_data = '0;
    logic [1:0] m_op = '0;
    int         m_n;
    bit         m_push;
    bit         m_free;
    cmd_t       m_cmd;
    cmd_t       m_head;
    res_t       m_res;
    logic       e_ready;
    logic [3:0] e_a;
    logic [3:0] e_b;
    logic [1:0] e_op;
    res_t       e_res;
    cmd_t       bp[6];
    logic [3:0] stream_exp[4];

    function automatic logic [3:0] lu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return a | b;
            2'b01:   return a ^ b;
            2'b10:   return a & b;
            default: return ~a;
        endcase
    endfunction

    assign result_in = lu(a_out, b_out, opcode_out);

    logic_cmd_sequencer #(.D_S(4), .D_W(2), .DEPTH(DEPTH)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .cmd_valid_in   (cmd_valid_in),
        .cmd_ready_out  (cmd_ready_out),
        .cmd_a_in       (cmd_a_in),
        .cmd_b_in       (cmd_b_in),
        .cmd_opcode_in  (cmd_opcode_in),
        .a_out          (a_out),
        .b_out          (b_out),
        .opcode_out     (opcode_out),
        .result_in      (result_in),
        .res_valid_out  (res_valid_out),
        .res_ready_in   (res_ready_in),
        .res_data_out   (res_data_out),
        .res_opcode_out (res_opcode_out),
        .count_out      (count_out)
    );

    initial forever #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [3:0] b,
                                 input logic [1:0] op, input logic rr);
        cmd_valid_in  = v;
        cmd_a_in      = a;
        cmd_b_in      = b;
        cmd_opcode_in = op;
        res_ready_in  = rr;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Model: a command queue plus one result slot, advanced on each rising edge.
    initial forever begin
        @(posedge clk_in);
        cyc++;
        if (!rst_n_in) begin
            q.delete();
            exp_q.delete();
            m_valid  = 1'b0;
            m_data   = '0;
            m_op     = '0;
            model_ok = 1'b1;
        end else begin
            m_n    = q.size();
            m_push = cmd_valid_in && (m_n < DEPTH);
            m_free = !m_valid || res_ready_in;
            m_cmd  = {cmd_a_in, cmd_b_in, cmd_opcode_in};
            if (m_push) begin
                m_res.d   = lu(m_cmd.a, m_cmd.b, m_cmd.op);
                m_res.op  = m_cmd.op;
                m_res.cyc = 0;
                exp_q.push_back(m_res);
            end
            if (m_n > 0 && m_free) begin
                m_head  = q.pop_front();
                m_valid = 1'b1;
                m_data  = lu(m_head.a, m_head.b, m_head.op);
                m_op    = m_head.op;
            end
`ifdef LOGIC_SEQ_BYPASS_EN
            else if (m_n == 0 && m_free && m_push) begin
                m_valid = 1'b1;
                m_data  = lu(m_cmd.a, m_cmd.b, m_cmd.op);
                m_op    = m_cmd.op;
                m_push  = 1'b0;
            end
`endif
            else if (res_ready_in) begin
                m_valid = 1'b0;
            end
            if (m_push) q.push_back(m_cmd);
        end
    end

    // Compare process: every falling edge, DUT against model, plus an in-order result scoreboard.
    initial forever begin
        @(negedge clk_in);
        if (model_ok) begin
            e_ready = rst_n_in && (q.size() < DEPTH);
            e_a = '0;
            e_b = '0;
            e_op = '0;
            if (q.size() > 0) begin
                e_a  = q[0].a;
                e_b  = q[0].b;
                e_op = q[0].op;
            end
`ifdef LOGIC_SEQ_BYPASS_EN
            else if (rst_n_in && cmd_valid_in && (!m_valid || res_ready_in)) begin
                e_a  = cmd_a_in;
                e_b  = cmd_b_in;
                e_op = cmd_opcode_in;
            end
`endif
            checkOutput("cmd_ready", int'(cmd_ready_out), int'(e_ready));
            checkOutput("count", int'(count_out), q.size());
            checkOutput("res_valid", int'(res_valid_out), int'(m_valid));
            checkOutput("a_out", int'(a_out), int'(e_a));
            checkOutput("b_out", int'(b_out), int'(e_b));
            checkOutput("opcode_out", int'(opcode_out), int'(e_op));
            if (m_valid) begin
                checkOutput("res_data", int'(res_data_out), int'(m_data));
                checkOutput("res_opcode", int'(res_opcode_out), int'(m_op));
            end
            if (rst_n_in && res_valid_out) vcount++;
            if (rst_n_in && res_valid_out && res_ready_in) begin
                e_res.d   = res_data_out;
                e_res.op  = res_opcode_out;
                e_res.cyc = cyc;
                got.push_back(e_res);
                checkOutput("sb_pending", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e_res = exp_q.pop_front();
                    checkOutput("sb_data", int'(res_data_out), int'(e_res.d));
                    checkOutput("sb_opcode", int'(res_opcode_out), int'(e_res.op));
                end
            end
        end
    end

    initial begin
        rst_n_in = 1'b0;
        applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
        stream_exp[0] = 4'b0111;
        stream_exp[1] = 4'b0110;
        stream_exp[2] = 4'b0001;
        stream_exp[3] = 4'b1100;
        bp[0] = {4'b1001, 4'b0011, 2'b00};
        for (int i = 1; i < 6; i++) bp[i] = cmd_t'($urandom);

        $display("[TB] reset");
        repeat (3) step();
        @(negedge clk_in);
        checkOutput("rst_cmd_ready", int'(cmd_ready_out), 0);
        checkOutput("rst_res_valid", int'(res_valid_out), 0);
        checkOutput("rst_count", int'(count_out), 0);
        checkOutput("rst_a", int'(a_out), 0);
        checkOutput("rst_b", int'(b_out), 0);
        checkOutput("rst_res_data", int'(res_data_out), 0);
        step();
        rst_n_in = 1'b1;
        @(negedge clk_in);
        checkOutput("post_rst_ready", int'(cmd_ready_out), 1);

        $display("[TB] single op");
        step();
        got.delete();
        vcount = 0;
        push_cyc = cyc;
        applyStimulus(1'b1, 4'b1100, 4'b1010, 2'b01, 1'b1);
        step();
        cmd_valid_in = 1'b0;
        repeat (5) step();
        checkOutput("single_count", got.size(), 1);
        checkOutput("single_pulse", vcount, 1);
        if (got.size() > 0) begin
            checkOutput("single_data", int'(got[0].d), 4'b0110);
            checkOutput("single_op", int'(got[0].op), 2'b01);
            checkOutput("single_latency", got[0].cyc - push_cyc, LAT);
        end

        $display("[TB] stream");
        got.delete();
        push_cyc = cyc;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'b0011, 4'b0101, 2'(i), 1'b1);
            step();
        end
        cmd_valid_in = 1'b0;
        repeat (6) step();
        checkOutput("stream_count", got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                checkOutput("stream_data", int'(got[i].d), int'(stream_exp[i]));
                checkOutput("stream_cycle", got[i].cyc, push_cyc + LAT + i);
            end
        end

        $display("[TB] back-pressure");
        got.delete();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, bp[i].a, bp[i].b, bp[i].op, 1'b0);
            step();
        end
        cmd_valid_in = 1'b0;
        @(negedge clk_in);
        checkOutput("bp_count", int'(count_out), 4);
        checkOutput("bp_ready", int'(cmd_ready_out), 0);
        checkOutput("bp_valid", int'(res_valid_out), 1);
        checkOutput("bp_data", int'(res_data_out), 4'b1011);
        repeat (3) step();
        @(negedge clk_in);
        checkOutput("bp_hold", int'(res_data_out), 4'b1011);
        step();
        res_ready_in = 1'b1;
        repeat (8) step();
        checkOutput("bp_drained", got.size(), 5);
        checkOutput("bp_final_count", int'(count_out), 0);
        for (int i = 0; i < 5; i++) begin
            if (i < got.size())
                checkOutput("bp_order", int'(got[i].d), int'(lu(bp[i].a, bp[i].b, bp[i].op)));
        end

        $display("[TB] simultaneous push/pop and wrap");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'b0);
            step();
        end
        cmd_valid_in = 1'b0;
        @(negedge clk_in);
        checkOutput("sim_pre_count", int'(count_out), 2);
        step();
        applyStimulus(1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'b1);
        step();
        applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
        @(negedge clk_in);
        checkOutput("sim_post_count", int'(count_out), 2);
        step();
        got.delete();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'b1);
            step();
        end
        cmd_valid_in = 1'b0;
        repeat (8) step();
        checkOutput("wrap_results", got.size(), 13);
        checkOutput("wrap_count", int'(count_out), 0);

        $display("[TB] mid-op reset");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'b0);
            step();
        end
        cmd_valid_in = 1'b0;
        @(negedge clk_in);
        checkOutput("mid_pre_count", int'(count_out), 3);
        checkOutput("mid_pre_valid", int'(res_valid_out), 1);
        step();
        rst_n_in = 1'b0;
        step();
        rst_n_in = 1'b1;
        @(negedge clk_in);
        checkOutput("mid_count", int'(count_out), 0);
        checkOutput("mid_valid", int'(res_valid_out), 0);
        got.delete();
        step();
        res_ready_in = 1'b1;
        repeat (5) step();
        checkOutput("mid_no_stale", got.size(), 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 2'($urandom),
                          1'($urandom_range(0, 9) < 7));
            rst_n_in = ($urandom_range(0, 63) != 0);
            step();
        end
        rst_n_in = 1'b1;
        applyStimulus(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
        repeat (10) step();
        checkOutput("final_outstanding", exp_q.size(), 0);
        checkOutput("final_count", int'(count_out), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
